// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types for the up/down triangle sweep controller.
// State encoding and default datapath widths.
package updown_sweep_ctrl_pkg;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Host/config and count-output bundle for the sweep controller.
// The master drives config, the slave returns count and status.
interface updown_sweep_ctrl_if
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = DEF_PCNT_W
);
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [PCNT_W-1:0] periods;
  logic [WIDTH-1:0]  q;
  logic              mode;
  logic              busy;
  logic              done;
  logic              err;
  logic              aborted;

  modport master (
    output start, abort, lo, hi, periods,
    input  q, mode, busy, done, err, aborted
  );

  modport slave (
    input  start, abort, lo, hi, periods,
    output q, mode, busy, done, err, aborted
  );
endinterface

// File: rtl/updown_sweep_ctrl_cnt.sv
// Loadable up/down counter, synchronous reset to zero.
// Load has priority over counting.
module updown_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (en)
      q <= mode ? q + 1'b1 : q - 1'b1;
  end
endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer: drives updown_cnt lo->hi->lo
// for a programmed number of periods, with abort and error pulses.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = DEF_PCNT_W
) (
  input  logic                clk,
  input  logic                rst,
  updown_sweep_ctrl_if.slave  bus
);
  state_t state, state_n;

  logic [WIDTH-1:0]  lo_r, hi_r, q;
  logic [PCNT_W-1:0] per_r, pcnt, pcnt_n, pcnt_inc;
  logic              cfg_ld;
  logic              cnt_en, cnt_ld, cnt_mode;
  logic              err_n, abt_n;
  logic              mode_r, busy_r, done_r, err_r, abt_r;

  assign pcnt_inc = pcnt + 1'b1;

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_ld),
    .load_val (bus.lo),
    .mode     (cnt_mode),
    .q        (q)
  );

  always_comb begin
    state_n  = state;
    pcnt_n   = pcnt;
    cfg_ld   = 1'b0;
    cnt_en   = 1'b0;
    cnt_ld   = 1'b0;
    cnt_mode = 1'b0;
    err_n    = 1'b0;
    abt_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cfg_ld = 1'b1;
          if (bus.lo >= bus.hi || bus.periods == '0) begin
            err_n = 1'b1;
          end else begin
            cnt_ld  = 1'b1;
            pcnt_n  = '0;
            state_n = UP;
          end
        end
      end
      UP: begin
        if (bus.abort) begin
          abt_n   = 1'b1;
          state_n = IDLE;
        end else if (q == hi_r) begin
          cnt_en  = 1'b1;
          state_n = DOWN;
        end else begin
          cnt_en   = 1'b1;
          cnt_mode = 1'b1;
        end
      end
      DOWN: begin
        if (bus.abort) begin
          abt_n   = 1'b1;
          state_n = IDLE;
        end else if (q == lo_r) begin
          pcnt_n = pcnt_inc;
          // Final period ends with q parked at lo.
          if (pcnt_inc == per_r) begin
            state_n = DONE;
          end else begin
            cnt_en   = 1'b1;
            cnt_mode = 1'b1;
            state_n  = UP;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pcnt   <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      per_r  <= '0;
      mode_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      abt_r  <= 1'b0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      if (cfg_ld) begin
        lo_r  <= bus.lo;
        hi_r  <= bus.hi;
        per_r <= bus.periods;
      end
      mode_r <= (state_n == UP);
      busy_r <= (state_n == UP) || (state_n == DOWN);
      done_r <= (state_n == DONE);
      err_r  <= err_n;
      abt_r  <= abt_n;
    end
  end

  assign bus.q       = q;
  assign bus.mode    = mode_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.aborted = abt_r;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_updown_sweep_ctrl;
  logic clk;
  logic rst;

  updown_sweep_ctrl_if #(.WIDTH(4), .PCNT_W(8)) bus();

  updown_sweep_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] q;
    logic       mode;
    logic       busy;
    logic       done;
    logic       err;
    logic       aborted;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(
    input logic r, input logic st, input logic ab,
    input logic [3:0] l, input logic [3:0] h, input logic [7:0] p,
    input logic [3:0] eq, input logic em, input logic eb,
    input logic ed, input logic ee, input logic ea,
    input string tag
  );
    exp_t x;
    rst = r;
    bus.start = st;
    bus.abort = ab;
    bus.lo = l;
    bus.hi = h;
    bus.periods = p;
    @(posedge clk);
    #1;
    x.q = eq; x.mode = em; x.busy = eb;
    x.done = ed; x.err = ee; x.aborted = ea;
    x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic idle(
    input logic [3:0] eq, input logic em, input logic eb,
    input logic ed, input logic ee, input logic ea,
    input string tag
  );
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0,
        eq, em, eb, ed, ee, ea, tag);
  endtask

  // Expected triangle: first period lo..hi..lo, later ones lo+1..hi..lo.
  task automatic sweep(
    input logic [3:0] l, input logic [3:0] h, input logic [7:0] p
  );
    int li = int'(l);
    int hi_i = int'(h);
    cyc(1'b0, 1'b1, 1'b0, l, h, p, l, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "start");
    for (int k = 0; k < int'(p); k++) begin
      for (int v = li + 1; v <= hi_i; v++)
        idle(4'(v), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "up");
      for (int v = hi_i - 1; v >= li; v--)
        idle(4'(v), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "down");
    end
    idle(l, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "done");
    cyc(1'b0, 1'b1, 1'b0, h, l, 8'd1,
        l, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "start_in_done");
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (bus.q !== e.q || bus.mode !== e.mode || bus.busy !== e.busy ||
          bus.done !== e.done || bus.err !== e.err ||
          bus.aborted !== e.aborted) begin
        errors++;
        $display("FAIL %s: got q=%0d mode=%b busy=%b done=%b err=%b ab=%b want q=%0d mode=%b busy=%b done=%b err=%b ab=%b",
                 e.tag, bus.q, bus.mode, bus.busy, bus.done, bus.err,
                 bus.aborted, e.q, e.mode, e.busy, e.done, e.err,
                 e.aborted);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    bus.periods = '0;

    cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 4'd0, 0, 0, 0, 0, 0, "reset");
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 8'd1, 4'd0, 0, 0, 0, 0, 0, "reset_start");
    idle(4'd0, 0, 0, 0, 0, 0, "post_reset");

    sweep(4'd2, 4'd5, 8'd1);
    sweep(4'd0, 4'd15, 8'd2);

    cyc(1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 8'd1, 4'd0, 0, 0, 0, 1, 0, "err_lo_eq_hi");
    idle(4'd0, 0, 0, 0, 0, 0, "err_clear");
    cyc(1'b0, 1'b1, 1'b0, 4'd1, 4'd3, 8'd0, 4'd0, 0, 0, 0, 1, 0, "err_per0");
    idle(4'd0, 0, 0, 0, 0, 0, "err_clear2");

    cyc(1'b0, 1'b1, 1'b0, 4'd1, 4'd6, 8'd1, 4'd1, 1, 1, 0, 0, 0, "ab_start");
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 8'd3, 4'd2, 1, 1, 0, 0, 0, "start_busy");
    idle(4'd3, 1, 1, 0, 0, 0, "ab_up3");
    idle(4'd4, 1, 1, 0, 0, 0, "ab_up4");
    cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd0, 4'd4, 0, 0, 0, 0, 1, "abort");
    idle(4'd4, 0, 0, 0, 0, 0, "ab_hold");
    cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd0, 4'd4, 0, 0, 0, 0, 0, "abort_idle");
    idle(4'd4, 0, 0, 0, 0, 0, "ab_idle2");

    cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 8'd1, 4'd0, 1, 1, 0, 0, 0, "rs_start");
    idle(4'd1, 1, 1, 0, 0, 0, "rs_up1");
    idle(4'd2, 1, 1, 0, 0, 0, "rs_up2");
    idle(4'd3, 1, 1, 0, 0, 0, "rs_up3");
    idle(4'd2, 0, 1, 0, 0, 0, "rs_down2");
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 4'd0, 0, 0, 0, 0, 0, "rst_mid_down");
    cyc(1'b0, 1'b1, 1'b1, 4'd1, 4'd4, 8'd1, 4'd0, 0, 0, 0, 0, 0, "start_abort");
    idle(4'd0, 0, 0, 0, 0, 0, "sa_idle");

    sweep(4'd1, 4'd3, 8'd3);

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
